// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and load/store
// masters, one transaction in flight, with anti-starvation for fetch.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    REQ_D,
    WAIT_I,
    WAIT_D
  } state_t;

  state_t     state;
  logic [1:0] streak;
  logic       fetch_wins;

  // Fetch wins when data is idle, or after three data grants in a row
  assign fetch_wins = inst_req &&
                      (!data_req || streak == 2'd3);

  // Grant FSM and data-grant streak counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_wins) begin
            state  <= REQ_I;
            streak <= 2'd0;
          end else if (data_req) begin
            state <= REQ_D;
            if (inst_req && streak != 2'd3)
              streak <= streak + 2'd1;
          end
        end
        REQ_I:
          if (bus_addr_ok) state <= WAIT_I;
        REQ_D:
          if (bus_addr_ok) state <= WAIT_D;
        WAIT_I:
          if (bus_data_ok) state <= IDLE;
        WAIT_D:
          if (bus_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus command and master responses muxed from the current owner
  always_comb begin
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_sel      = 4'b0000;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (!rst) begin
      unique case (state)
        REQ_I: begin
          bus_req      = 1'b1;
          bus_sel      = 4'b1111;
          bus_addr     = inst_addr;
          inst_addr_ok = bus_addr_ok;
        end
        REQ_D: begin
          bus_req      = 1'b1;
          bus_we       = data_we;
          bus_sel      = data_sel;
          bus_addr     = data_addr;
          bus_wdata    = data_wdata;
          data_addr_ok = bus_addr_ok;
        end
        WAIT_I: begin
          inst_data_ok = bus_data_ok;
          if (bus_data_ok) inst_rdata = bus_rdata;
        end
        WAIT_D: begin
          data_data_ok = bus_data_ok;
          if (bus_data_ok) data_rdata = bus_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the bus data width.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  load/store request, held until data_addr_ok
- data_we  in  1  1 = store
- data_sel  in  4  byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  load/store address accepted
- data_data_ok  out  1  load data valid / store done
- data_rdata  out  DATA_W  load data
- bus_req  out  1  shared bus request
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/ADDR_W/DATA_W  shared bus command
- bus_addr_ok  in  1  bus accepted command
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  DATA_W  bus read data

Function
REQ-004 The FSM SHALL have states IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D, with exactly one transaction outstanding at any time.
REQ-005 IDLE SHALL hold bus_req=0; the cycle after a request is seen, the FSM SHALL enter REQ_D or REQ_I, so grant latency is 1 cycle.
REQ-006 Arbitration SHALL give data priority over fetch, except when streak==3 and inst_req=1, in which case fetch wins.
REQ-007 streak SHALL be a 2-bit saturating counter that increments on each data grant taken while inst_req=1, and clears on each fetch grant.
REQ-008 In REQ_x, bus_req SHALL be 1 and the bus command fields SHALL be muxed combinationally from owner x; for fetch, bus_we=0 and bus_sel=4'b1111. The owner SHALL NOT change until bus_addr_ok.
REQ-009 In REQ_x with bus_addr_ok=1, x_addr_ok SHALL pulse for that cycle only, and the FSM SHALL enter WAIT_x.
REQ-010 In WAIT_x, bus_req SHALL be 0; bus_data_ok=1 SHALL drive x_data_ok=1 combinationally with x_rdata=bus_rdata, and the FSM SHALL return to IDLE.
REQ-011 bus_data_ok arriving in IDLE or REQ_x SHALL be ignored and not forwarded.
REQ-012 The non-owner's addr_ok and data_ok SHALL be 0 at all times.
REQ-013 inst_rdata and data_rdata SHALL equal bus_rdata when their data_ok=1, and SHALL be 0 otherwise.
REQ-014 A request deasserted in REQ_x before bus_addr_ok is a master protocol violation; the behaviour SHALL NOT be defined and SHALL NOT be required in verification.
REQ-015 Minimum transaction time SHALL be 3 cycles, IDLE to IDLE, when bus_addr_ok and bus_data_ok are both immediate.

Reset
REQ-016 With rst=1 at a clock edge, the FSM SHALL go to IDLE and streak SHALL clear to 0.
REQ-017 During reset, bus_req and all *_addr_ok and *_data_ok outputs SHALL be 0, and all data/address outputs SHALL be 0.
REQ-018 Reset in WAIT_x SHALL abandon the transaction; a later bus_data_ok SHALL be ignored per REQ-011.

Verification
REQ-019 Fetch only: inst_req=1, addr 0x1C000000, bus_addr_ok immediate, bus_data_ok next cycle with rdata 0x02800000 -> inst_addr_ok at cycle 2, inst_data_ok with rdata 0x02800000 at cycle 3.
REQ-020 Simultaneous requests: inst_req=1 and data_req=1 in IDLE -> data granted first, then fetch granted; streak=1 after the data grant.
REQ-021 Starvation: data_req and inst_req held high continuously -> grant order D,D,D,I,D,D,D,I.
REQ-022 Store with bus_addr_ok delayed 4 cycles, data_sel=4'b0011, wdata 0xABCD1234 -> bus_addr, bus_sel and bus_wdata stable throughout REQ_D; data_addr_ok pulses exactly once.
REQ-023 Reset asserted in WAIT_D, then bus_data_ok pulsed -> data_data_ok stays 0, FSM in IDLE, streak=0.
REQ-024 Stray bus_data_ok in IDLE -> no data_ok output asserted and no state change.
